// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB arbiter that never moves ownership inside
// a fixed-length burst or while the owner holds HLOCK with HBUSREQ.
// Ports: HCLK, HRESETn (async, active-low); HBUSREQ/HLOCK per master;
// HTRANS/HBURST of the current owner; HREADY bus-wide ready;
// HGRANT one-hot grant; HMASTER/HMASTER_D address/data-phase owner;
// HMASTLOCK locked address phase. All outputs registered.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MASTER_W       = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MASTER_W-1:0]    HMASTER,
  output logic [MASTER_W-1:0]    HMASTER_D,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  localparam logic [NUM_MASTERS-1:0] DEF_GNT =
    NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MASTER_W-1:0] DEF_IDX = MASTER_W'(DEFAULT_MASTER);

  logic [3:0]          cnt;
  logic [3:0]          next_cnt;
  logic [MASTER_W-1:0] grant_idx;
  logic [MASTER_W-1:0] win_idx;
  logic                grant_lock;
  logic                lock_hold;
  logic                arb_ok;
  logic                found;

  // Index of the current grantee and its lock request.
  always_comb begin
    grant_idx  = '0;
    grant_lock = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (HGRANT[i]) begin
        grant_idx  = MASTER_W'(i);
        grant_lock = HLOCK[i];
      end
    end
  end

  // SEQ beats still owed after this address phase.
  always_comb begin
    next_cnt = cnt;
    case (HTRANS)
      T_IDLE: next_cnt = '0;
      T_BUSY: next_cnt = cnt;
      T_NSEQ: begin
        case (HBURST)
          3'b000, 3'b001: next_cnt = 4'd0;
          3'b010, 3'b011: next_cnt = 4'd3;
          3'b100, 3'b101: next_cnt = 4'd7;
          default:        next_cnt = 4'd15;
        endcase
      end
      T_SEQ: next_cnt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
      default: next_cnt = cnt;
    endcase
  end

  // Owner keeps the bus while it both locks and requests.
  always_comb begin
    lock_hold = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (HMASTER == MASTER_W'(i))
        lock_hold = HLOCK[i] & HBUSREQ[i];
    end
  end

  // Rotating search starting just after the grantee; the grantee
  // itself is tried last so it keeps the bus only when alone.
  always_comb begin
    win_idx = DEF_IDX;
    found   = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!found && HBUSREQ[j] &&
            j == (int'(grant_idx) + k) % NUM_MASTERS) begin
          found   = 1'b1;
          win_idx = MASTER_W'(j);
        end
      end
    end
  end

  // Re-arbitrate on the last-but-one beat so the handover has no gap.
  assign arb_ok = HREADY & (next_cnt <= 4'd1) & ~lock_hold;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HGRANT    <= DEF_GNT;
      HMASTER   <= DEF_IDX;
      HMASTER_D <= DEF_IDX;
      HMASTLOCK <= 1'b0;
      cnt       <= '0;
    end else begin
      if (arb_ok)
        HGRANT <= NUM_MASTERS'(1) << win_idx;
      if (HREADY) begin
        cnt       <= next_cnt;
        HMASTER   <= grant_idx;
        HMASTER_D <= HMASTER;
        HMASTLOCK <= grant_lock;
      end
    end
  end

endmodule
